mac_job_seq: RTL and testbench



---
 rtl/mac_job_seq.sv | 165 ++++++++++++++++
 tb/tb_mac_job_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_job_seq.sv
// Job sequencer for the MAC HWPE control path: queues job descriptors, walks each job's
// iterations with per-stream base/stride addressing, and signals completion to a core.
module mac_job_seq #(
   parameter int N_CORES   = 2,
   parameter int N_CONTEXT = 2,
   parameter int N_STREAMS = 3,
   parameter int ADDR_W    = 32,
   parameter int ITER_W    = 16,
   parameter int LEN_W     = 16,
   parameter int CORE_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   input  logic                          job_valid_i,
   output logic                          job_ready_o,
   input  logic [CORE_W-1:0]             job_core_i,
   input  logic [ITER_W-1:0]             job_nb_iter_i,
   input  logic [LEN_W-1:0]              job_len_i,
   input  logic [N_STREAMS*ADDR_W-1:0]   job_base_i,
   input  logic [N_STREAMS*ADDR_W-1:0]   job_stride_i,
   input  logic [N_STREAMS-1:0]          stream_ready_i,
   output logic [N_STREAMS-1:0]          stream_req_o,
   output logic [N_STREAMS*ADDR_W-1:0]   stream_addr_o,
   output logic [LEN_W:0]                stream_len_o,
   output logic                          engine_start_o,
   input  logic                          engine_done_i,
   output logic [N_CORES-1:0]            evt_o,
   output logic                          busy_o,
   output logic [$clog2(N_CONTEXT):0]    queue_cnt_o
);

   localparam int PTR_W = $clog2(N_CONTEXT);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, DONE} state_t;

   state_t                        state;
   logic [CORE_W-1:0]             q_core   [N_CONTEXT];
   logic [ITER_W-1:0]             q_nb     [N_CONTEXT];
   logic [LEN_W-1:0]              q_len    [N_CONTEXT];
   logic [N_STREAMS*ADDR_W-1:0]   q_base   [N_CONTEXT];
   logic [N_STREAMS*ADDR_W-1:0]   q_stride [N_CONTEXT];
   logic [PTR_W-1:0]              wr_ptr;
   logic [PTR_W-1:0]              rd_ptr;
   logic [CNT_W-1:0]              count;
   logic                          push;
   logic                          pop;
   logic                          flush;
   logic                          issue_go;

   logic [CORE_W-1:0]             core_r;
   logic [ITER_W-1:0]             nb_iter_r;
   logic [ITER_W-1:0]             iter;
   logic [LEN_W:0]                len_r;
   logic [ADDR_W-1:0]             addr_r   [N_STREAMS];
   logic [ADDR_W-1:0]             stride_r [N_STREAMS];

   // Modulo-2^ADDR_W advance; a negative stride arrives already in two's complement.
   function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] s);
      return a + s;
   endfunction

   assign flush       = rst_i | clear_i;
   assign job_ready_o = (count < CNT_W'(N_CONTEXT));
   assign push        = job_valid_i & job_ready_o;
   assign pop         = (state == LOAD);
   assign queue_cnt_o = count;
   assign busy_o      = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < N_CONTEXT; i++) begin
            q_core[i]   <= '0;
            q_nb[i]     <= '0;
            q_len[i]    <= '0;
            q_base[i]   <= '0;
            q_stride[i] <= '0;
         end
      end else begin
         if (push) begin
            q_core[wr_ptr]   <= job_core_i;
            q_nb[wr_ptr]     <= job_nb_iter_i;
            q_len[wr_ptr]    <= job_len_i;
            q_base[wr_ptr]   <= job_base_i;
            q_stride[wr_ptr] <= job_stride_i;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (flush) begin
         state     <= IDLE;
         core_r    <= '0;
         nb_iter_r <= '0;
         iter      <= '0;
         len_r     <= '0;
         for (int s = 0; s < N_STREAMS; s++) begin
            addr_r[s]   <= '0;
            stride_r[s] <= '0;
         end
      end else begin
         case (state)
            IDLE: if (count != '0) state <= LOAD;
            LOAD: begin
               core_r    <= q_core[rd_ptr];
               nb_iter_r <= q_nb[rd_ptr];
               len_r     <= {1'b0, q_len[rd_ptr]} + 1'b1;
               iter      <= '0;
               for (int s = 0; s < N_STREAMS; s++) begin
                  addr_r[s]   <= q_base[rd_ptr][s*ADDR_W +: ADDR_W];
                  stride_r[s] <= q_stride[rd_ptr][s*ADDR_W +: ADDR_W];
               end
               state <= ISSUE;
            end
            ISSUE: if (issue_go) state <= RUN;
            RUN: begin
               if (engine_done_i) begin
                  if (iter == nb_iter_r) begin
                     state <= DONE;
                  end else begin
                     iter <= iter + 1'b1;
                     for (int s = 0; s < N_STREAMS; s++)
                        addr_r[s] <= addr_step(addr_r[s], stride_r[s]);
                     state <= ISSUE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Start pulses follow streamer readiness within the ISSUE cycle itself.
   assign issue_go       = (state == ISSUE) && (&stream_ready_i);
   assign engine_start_o = issue_go;
   assign stream_req_o   = issue_go ? '1 : '0;
   assign stream_len_o   = len_r;

   for (genvar s = 0; s < N_STREAMS; s++) begin : g_addr
      assign stream_addr_o[s*ADDR_W +: ADDR_W] = addr_r[s];
   end

   always_comb begin
      evt_o = '0;
      if (state == DONE) begin
         for (int c = 0; c < N_CORES; c++)
            if (core_r == CORE_W'(c)) evt_o[c] = 1'b1;
      end
   end

endmodule

// File: tb/tb_mac_job_seq.sv
// Randomized and directed bench for mac_job_seq, checked against a job-level model that
// expands each accepted descriptor into its expected issue addresses and completion event.
module tb_mac_job_seq;

   localparam int N_CORES   = 2;
   localparam int N_CONTEXT = 2;
   localparam int N_STREAMS = 3;
   localparam int ADDR_W    = 32;
   localparam int ITER_W    = 16;
   localparam int LEN_W     = 16;
   localparam int CORE_W    = 1;
   localparam int SW        = N_STREAMS * ADDR_W;

   logic              clk = 1'b0;
   logic              rst_i, clear_i, job_valid_i, job_ready_o;
   logic [CORE_W-1:0] job_core_i;
   logic [ITER_W-1:0] job_nb_iter_i;
   logic [LEN_W-1:0]  job_len_i;
   logic [SW-1:0]     job_base_i, job_stride_i;
   logic [N_STREAMS-1:0] stream_ready_i, stream_req_o;
   logic [SW-1:0]     stream_addr_o;
   logic [LEN_W:0]    stream_len_o;
   logic              engine_start_o, engine_done_i;
   logic [N_CORES-1:0] evt_o;
   logic              busy_o;
   logic [1:0]        queue_cnt_o;

   logic auto_done = 1'b0, man_done = 1'b0, auto_en = 1'b0;
   int   fix_dly = 0;
   int   n_vec = 0, n_err = 0;
   logic prev_start = 1'b0, prev_evt = 1'b0;
   logic [ADDR_W-1:0] last_addr0 = '0;

   logic [SW-1:0]  exp_addr[$];
   logic [LEN_W:0] exp_len[$];
   int             exp_evt[$];

   assign engine_done_i = auto_done | man_done;

   always #5 clk = ~clk;

   mac_job_seq #(.N_CORES(N_CORES), .N_CONTEXT(N_CONTEXT), .N_STREAMS(N_STREAMS),
                 .ADDR_W(ADDR_W), .ITER_W(ITER_W), .LEN_W(LEN_W), .CORE_W(CORE_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_core_i(job_core_i),
      .job_nb_iter_i(job_nb_iter_i), .job_len_i(job_len_i),
      .job_base_i(job_base_i), .job_stride_i(job_stride_i),
      .stream_ready_i(stream_ready_i), .stream_req_o(stream_req_o),
      .stream_addr_o(stream_addr_o), .stream_len_o(stream_len_o),
      .engine_start_o(engine_start_o), .engine_done_i(engine_done_i),
      .evt_o(evt_o), .busy_o(busy_o), .queue_cnt_o(queue_cnt_o));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One job expands to nb+1 issues at base + k*stride (mod 2^32) and one event.
   task automatic model_add(input int core, input int nb, input logic [LEN_W-1:0] len,
                            input logic [SW-1:0] base, input logic [SW-1:0] stride);
      logic [SW-1:0]     a;
      logic [ADDR_W-1:0] b, st;
      for (int k = 0; k <= nb; k++) begin
         for (int s = 0; s < N_STREAMS; s++) begin
            b  = base[s*ADDR_W +: ADDR_W];
            st = stride[s*ADDR_W +: ADDR_W];
            a[s*ADDR_W +: ADDR_W] = b + st * 32'(k);
         end
         exp_addr.push_back(a);
         exp_len.push_back(17'(len) + 17'd1);
      end
      exp_evt.push_back(core);
   endtask

   // Called at posedge+1; returns at posedge+1 of the following cycle.
   task automatic push(input int core, input int nb, input logic [LEN_W-1:0] len,
                       input logic [SW-1:0] base, input logic [SW-1:0] stride);
      job_core_i    = CORE_W'(core);
      job_nb_iter_i = ITER_W'(nb);
      job_len_i     = len;
      job_base_i    = base;
      job_stride_i  = stride;
      job_valid_i   = 1'b1;
      @(negedge clk);
      check("push_ready", job_ready_o, 1'b1);
      if (job_ready_o) model_add(core, nb, len, base, stride);
      @(posedge clk); #1;
      job_valid_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      @(negedge clk);
      while (!engine_start_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, engine_start_o, 1'b1);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      @(negedge clk);
      while ((busy_o || exp_addr.size() != 0 || exp_evt.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, exp_evt.size(), 0);
      check({tag, "_iss"}, exp_addr.size(), 0);
      check({tag, "_idle"}, busy_o, 1'b0);
      @(posedge clk); #1;
   endtask

   // Engine model: answers each start with a done pulse a few cycles later.
   initial begin
      int d;
      forever begin
         @(negedge clk);
         if (auto_en && engine_start_o) begin
            d = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 5));
            repeat (d) @(posedge clk);
            #1 auto_done = 1'b1;
            @(posedge clk);
            #1 auto_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_i) begin
         prev_start <= 1'b0;
         prev_evt   <= 1'b0;
      end else begin
         if (engine_start_o || stream_req_o != '0) begin
            check("start_pair", {engine_start_o, stream_req_o}, 4'b1111);
            check("start_rdy", stream_ready_i, 3'b111);
            check("start_single", prev_start, 1'b0);
            if (exp_addr.size() == 0) begin
               check("start_unexpected", 1'b1, 1'b0);
            end else begin
               logic [SW-1:0] ea;
               ea = exp_addr.pop_front();
               for (int s = 0; s < N_STREAMS; s++)
                  check($sformatf("addr%0d", s), stream_addr_o[s*ADDR_W +: ADDR_W],
                        ea[s*ADDR_W +: ADDR_W]);
               check("len", stream_len_o, exp_len.pop_front());
               last_addr0 <= stream_addr_o[ADDR_W-1:0];
            end
         end
         if (evt_o != '0) begin
            check("evt_single", prev_evt, 1'b0);
            if (exp_evt.size() == 0) check("evt_unexpected", evt_o, 2'b00);
            else check("evt", evt_o, 2'b01 << exp_evt.pop_front());
         end
         prev_start <= engine_start_o;
         prev_evt   <= (evt_o != '0);
      end
   end

   initial begin
      rst_i = 1'b1; clear_i = 1'b0; job_valid_i = 1'b0; job_core_i = '0;
      job_nb_iter_i = '0; job_len_i = '0; job_base_i = '0; job_stride_i = '0;
      stream_ready_i = 3'b111;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("rst_ready", job_ready_o, 1'b1);
      check("rst_req", stream_req_o, 3'b000);
      check("rst_addr", stream_addr_o == '0, 1'b1);
      check("rst_len", stream_len_o, 17'd0);
      check("rst_start", engine_start_o, 1'b0);
      check("rst_evt", evt_o, 2'b00);
      check("rst_busy", busy_o, 1'b0);
      check("rst_cnt", queue_cnt_o, 2'd0);
      step();

      // Single job, three iterations, done 4 cycles after each start.
      auto_en = 1'b1; fix_dly = 4;
      push(1, 2, 16'd15, {32'h300, 32'h200, 32'h100}, {32'h10, 32'h40, 32'h40});
      @(negedge clk);
      check("t1_c1_busy", busy_o, 1'b0);
      check("t1_c1_cnt", queue_cnt_o, 2'd1);
      step(); @(negedge clk);
      check("t1_c2_busy", busy_o, 1'b1);
      check("t1_c2_start", engine_start_o, 1'b0);
      step(); @(negedge clk);
      check("t1_c3_start", engine_start_o, 1'b1);
      check("t1_len", stream_len_o, 17'd16);
      wait_drain("t1_drain", 100);
      check("t1_last_addr0", last_addr0, 32'h180);

      // Queue full and refusal in the pop cycle.
      auto_en = 1'b0; fix_dly = 0;
      push(0, 0, 16'd3, {32'h3000, 32'h2000, 32'h1000}, '0);
      wait_start("qf_a_start");
      step();
      push(1, 1, 16'd7, {32'h30, 32'h20, 32'h10}, {32'h4, 32'h4, 32'h4});
      push(0, 0, 16'd1, {32'h33, 32'h22, 32'h11}, '0);
      @(negedge clk);
      check("qf_full_ready", job_ready_o, 1'b0);
      check("qf_full_cnt", queue_cnt_o, 2'd2);
      step(); man_done = 1'b1;
      step(); man_done = 1'b0; auto_en = 1'b1;
      @(negedge clk);
      check("qf_evt_a", evt_o, 2'b01);
      step(); @(negedge clk);
      check("qf_idle", busy_o, 1'b0);
      check("qf_idle_evt", evt_o, 2'b00);
      step();
      job_core_i = 1'b1; job_nb_iter_i = '0; job_len_i = 16'd2;
      job_base_i = {32'h66, 32'h55, 32'h44}; job_stride_i = '0; job_valid_i = 1'b1;
      @(negedge clk);
      check("qf_pop_busy", busy_o, 1'b1);
      check("qf_pop_ready", job_ready_o, 1'b0);
      check("qf_pop_cnt", queue_cnt_o, 2'd2);
      step(); @(negedge clk);
      check("qf_next_ready", job_ready_o, 1'b1);
      check("qf_next_cnt", queue_cnt_o, 2'd1);
      if (job_ready_o) model_add(1, 0, 16'd2, {32'h66, 32'h55, 32'h44}, '0);
      step(); job_valid_i = 1'b0;
      @(negedge clk);
      check("qf_after_cnt", queue_cnt_o, 2'd2);
      wait_drain("qf_drain", 200);

      // Backpressure in ISSUE.
      stream_ready_i = 3'b101;
      push(1, 0, 16'd4, {32'hC, 32'hB, 32'hA}, '0);
      step(); step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_start", engine_start_o, 1'b0);
         check("bp_req", stream_req_o, 3'b000);
         check("bp_busy", busy_o, 1'b1);
         step();
      end
      stream_ready_i = 3'b111;
      @(negedge clk);
      check("bp_release_start", engine_start_o, 1'b1);
      check("bp_release_req", stream_req_o, 3'b111);
      wait_drain("bp_drain", 100);

      // Address wrap-around.
      push(0, 1, 16'd0, {3{32'hFFFF_FFF0}}, {3{32'h20}});
      wait_drain("wrap_drain", 100);
      check("wrap_addr0", last_addr0, 32'h0000_0010);

      // Mid-job clear with one job queued.
      auto_en = 1'b0;
      push(1, 3, 16'd9, {32'h900, 32'h800, 32'h700}, {32'h8, 32'h8, 32'h8});
      wait_start("clr_start");
      step();
      push(0, 0, 16'd1, {32'h1, 32'h2, 32'h3}, '0);
      @(negedge clk);
      check("clr_pre_cnt", queue_cnt_o, 2'd1);
      step(); clear_i = 1'b1;
      exp_addr.delete(); exp_len.delete(); exp_evt.delete();
      step(); clear_i = 1'b0;
      @(negedge clk);
      check("clr_busy", busy_o, 1'b0);
      check("clr_cnt", queue_cnt_o, 2'd0);
      check("clr_evt", evt_o, 2'b00);
      check("clr_ready", job_ready_o, 1'b1);
      check("clr_addr", stream_addr_o == '0, 1'b1);
      step(); man_done = 1'b1;
      step(); man_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("clr_done_busy", busy_o, 1'b0);
         check("clr_done_evt", evt_o, 2'b00);
         step();
      end

      // Spurious done in IDLE and in ISSUE.
      man_done = 1'b1;
      step(); man_done = 1'b0;
      @(negedge clk);
      check("sp_idle_busy", busy_o, 1'b0);
      check("sp_idle_evt", evt_o, 2'b00);
      step();
      auto_en = 1'b1; stream_ready_i = 3'b000;
      push(0, 0, 16'd5, {32'hF0, 32'hE0, 32'hD0}, '0);
      step(); step();
      man_done = 1'b1;
      @(negedge clk);
      check("sp_issue_start", engine_start_o, 1'b0);
      step(); man_done = 1'b0;
      @(negedge clk);
      check("sp_issue_busy", busy_o, 1'b1);
      check("sp_issue_evt", evt_o, 2'b00);
      step(); stream_ready_i = 3'b111;
      @(negedge clk);
      check("sp_issue_go", engine_start_o, 1'b1);
      wait_drain("sp_drain", 100);

      // Randomized traffic with random backpressure and engine latency.
      for (int i = 0; i < 600; i++) begin
         stream_ready_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
         job_valid_i    = ($urandom_range(0, 5) == 0);
         job_core_i     = CORE_W'($urandom_range(0, 1));
         job_nb_iter_i  = ITER_W'($urandom_range(0, 3));
         job_len_i      = LEN_W'($urandom);
         job_base_i     = {$urandom, $urandom, $urandom};
         job_stride_i   = {$urandom, $urandom, $urandom};
         @(negedge clk);
         if (job_valid_i && job_ready_o)
            model_add(int'(job_core_i), int'(job_nb_iter_i), job_len_i, job_base_i, job_stride_i);
         step();
      end
      job_valid_i = 1'b0; stream_ready_i = 3'b111;
      wait_drain("rnd_drain", 2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
